load_store_unit: RTL and testbench

Sits between the core's memory stage and the word-addressed `memory` block. It accepts one byte, halfword or word load/store at a time over a valid/ready handshake and drives `memory`'s combinational read port and synchronous write port. Sub-word stores are performed as read-modify-write. Loads are sign- or zero-extended. Word-crossing accesses are optionally split into two word accesses.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states, access-size decode.
// Size 0 from size_decode marks an illegal funct3 for the given direction.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] SIZE_INVALID = 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_RESP
    } state_e;

    function automatic logic [2:0] size_decode(input logic we, input logic [2:0] f3);
        logic [2:0] sz;
        sz = SIZE_INVALID;
        case (f3[1:0])
            2'b00:   sz = 3'd1;
            2'b01:   sz = 3'd2;
            2'b10:   sz = 3'd4;
            default: sz = SIZE_INVALID;
        endcase
        // Stores have no unsigned variants; loads have no 110 (LWU on RV32).
        if (f3[2] && (we || f3[1]))
            sz = SIZE_INVALID;
        return sz;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for one memory word of an access (word 0 or the spill word 1).
// Produces the lane mask, the read-modify-write merge and the load bytes packed at data positions.
module lsu_lane_align (
    input  logic [1:0]  off_i,
    input  logic [2:0]  size_i,
    input  logic        word_idx_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rd_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wd_o,
    output logic [31:0] ld_o
);

    logic [2:0] idx;
    logic [1:0] lane;
    logic       hit;

    always_comb begin
        mask_o = '0;
        wd_o   = mem_rd_i;
        ld_o   = '0;
        idx    = '0;
        lane   = '0;
        hit    = 1'b0;
        for (int l = 0; l < 4; l++) begin
            lane = 2'(l);
            // Data byte index carried by this lane; word 1 holds the bytes that spilled past lane 3.
            idx  = word_idx_i ? (3'(l) + 3'd4 - {1'b0, off_i}) : (3'(l) - {1'b0, off_i});
            hit  = (word_idx_i ? (lane < off_i) : (lane >= off_i)) && (idx < size_i);
            if (hit) begin
                mask_o[l]                    = 1'b1;
                wd_o[8*l +: 8]               = wdata_i[{idx[1:0], 3'b000} +: 8];
                ld_o[{idx[1:0], 3'b000} +: 8] = mem_rd_i[8*l +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit with RMW sub-word stores; 2 cycles to response (3 if split), faults in 1.
// One request in flight, req_ready only in IDLE; response held until resp_ready. Macro LSU_MISALIGNED_EN splits word-crossing accesses.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_ra,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, ld_q, ld_d;
    logic [2:0]  f3_q;
    logic        we_q, fault_q, fault_d;

    logic [2:0]  size_q, req_size;
    logic        accept, acc, word_idx, req_bad;
    logic [3:0]  lane_mask;
    logic [31:0] merged, ld_bytes, base, ext;

    assign size_q   = size_decode(we_q, f3_q);
    assign req_size = size_decode(req_we, req_funct3);
    assign accept   = req_valid && (state_q == S_IDLE);
    assign acc      = (state_q == S_ACC0) || (state_q == S_ACC1);
    assign base     = {addr_q[31:2], 2'b00};

`ifdef LSU_MISALIGNED_EN
    logic cross_q;
    assign cross_q  = ({2'b00, addr_q[1:0]} + {1'b0, size_q}) > 4'd4;
    assign word_idx = (state_q == S_ACC1);
    assign req_bad  = (req_size == SIZE_INVALID);
`else
    assign word_idx = 1'b0;
    assign req_bad  = (req_size == SIZE_INVALID) ||
                      (({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4);
`endif

    lsu_lane_align u_align (
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .word_idx_i (word_idx),
        .wdata_i    (wdata_q),
        .mem_rd_i   (mem_rd),
        .mask_o     (lane_mask),
        .wd_o       (merged),
        .ld_o       (ld_bytes)
    );

    // Read and write share one address so the RMW merge sees the word it overwrites.
    assign mem_ra = acc ? (word_idx ? base + 32'd4 : base) : 32'd0;
    assign mem_wa = mem_ra;
    assign mem_we = acc && we_q;
    assign mem_wd = mem_we ? merged : 32'd0;

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        ld_d    = ld_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    fault_d = req_bad;
                    ld_d    = '0;
                    state_d = req_bad ? S_RESP : S_ACC0;
                end
            end
            S_ACC0: begin
                ld_d = ld_q | ld_bytes;
`ifdef LSU_MISALIGNED_EN
                state_d = cross_q ? S_ACC1 : S_RESP;
`else
                state_d = S_RESP;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            S_ACC1: begin
                ld_d    = ld_q | ld_bytes;
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            ld_q    <= ld_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
                we_q    <= req_we;
            end
        end
    end

    always_comb begin
        ext = '0;
        case (f3_q)
            F3_LB:   ext = {{24{ld_q[7]}}, ld_q[7:0]};
            F3_LH:   ext = {{16{ld_q[15]}}, ld_q[15:0]};
            F3_LW:   ext = ld_q;
            F3_LBU:  ext = {24'd0, ld_q[7:0]};
            F3_LHU:  ext = {16'd0, ld_q[15:0]};
            default: ext = '0;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_fault = resp_valid && fault_q;
    assign resp_rdata = (resp_valid && !fault_q && !we_q) ? ext : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model; expectations follow the LSU_MISALIGNED_EN build.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_ra, mem_wa, mem_wd, mem_rd;

    logic [1:0]  la_off;
    logic [2:0]  la_size;
    logic        la_widx;
    logic [31:0] la_wdata, la_rd, la_wd, la_ld;
    logic [3:0]  la_mask;

    logic [31:0] mem [16];
    int          we_cnt = 0;
    logic [31:0] last_wa;
    logic        poke_en;
    logic [31:0] poke_a, poke_d;
    logic [31:0] ra_log [4];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat, nwe;

    always #5 clk = ~clk;

    function automatic logic [3:0] widx(input logic [31:0] a);
        return {a[8], a[4:2]};
    endfunction

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_we     (mem_we),
        .mem_ra     (mem_ra),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    lsu_lane_align u_la (
        .off_i      (la_off),
        .size_i     (la_size),
        .word_idx_i (la_widx),
        .wdata_i    (la_wdata),
        .mem_rd_i   (la_rd),
        .mask_o     (la_mask),
        .wd_o       (la_wd),
        .ld_o       (la_ld)
    );

    assign mem_rd = mem[widx(mem_ra)];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[widx(mem_wa)] <= mem_wd;
            we_cnt            <= we_cnt + 1;
            last_wa           <= mem_wa;
        end else if (poke_en) begin
            mem[widx(poke_a)] <= poke_d;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Issues one request from an IDLE cycle and returns in the response cycle (or after a bounded wait).
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int l, output int n);
        int w0;
        w0         = we_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        check("req_ready_before_send", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        l = 1;
        while (!resp_valid && l < 8) begin
            if (l <= 4) ra_log[l-1] = mem_ra;
            @(posedge clk); #1;
            l++;
        end
        n = we_cnt - w0;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1; poke_en = 1'b0;
        poke_a = '0; poke_d = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #12;
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        check("rst_mem_we",     {31'd0, mem_we},     32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_ra",     mem_ra, 32'd0);
        check("rst_mem_wa",     mem_wa, 32'd0);
        check("rst_mem_wd",     mem_wd, 32'd0);

        // Standalone lane alignment: SW at offset 2, both words, and SB at offset 1.
        la_off = 2'd2; la_size = 3'd4; la_widx = 1'b0; la_wdata = 32'h11223344; la_rd = 32'hAAAAAAAA;
        #1;
        check("la_w0_mask", {28'd0, la_mask}, 32'h0000000C);
        check("la_w0_wd",   la_wd, 32'h3344AAAA);
        check("la_w0_ld",   la_ld, 32'h0000AAAA);
        la_widx = 1'b1;
        #1;
        check("la_w1_mask", {28'd0, la_mask}, 32'h00000003);
        check("la_w1_wd",   la_wd, 32'hAAAA1122);
        check("la_w1_ld",   la_ld, 32'hAAAA0000);
        la_off = 2'd1; la_size = 3'd1; la_widx = 1'b0; la_wdata = 32'h12345677; la_rd = 32'h8899AABB;
        #1;
        check("la_b_mask", {28'd0, la_mask}, 32'h00000002);
        check("la_b_wd",   la_wd, 32'h889977BB);
        check("la_b_ld",   la_ld, 32'h000000AA);

        @(posedge clk); #1;
        rst_n = 1'b1;
        poke(32'h100, 32'h8899AABB);

        send(1'b0, F3_LB, 32'h101, 32'h0, lat, nwe);
        check("lb_rdata", resp_rdata, 32'hFFFFFFAA);
        check("lb_fault", {31'd0, resp_fault}, 32'd0);
        check("lb_lat",   lat, 2);
        check("lb_nwe",   nwe, 0);
        finish_resp();

        send(1'b0, F3_LHU, 32'h102, 32'h0, lat, nwe);
        check("lhu_hi_rdata", resp_rdata, 32'h00008899);
        finish_resp();

        resp_ready = 1'b0;
        send(1'b0, F3_LHU, 32'h100, 32'h0, lat, nwe);
        check("lhu_lo_rdata", resp_rdata, 32'h0000AABB);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, 32'h0000AABB);
        end
        finish_resp();
        check("post_hold_valid", {31'd0, resp_valid}, 32'd0);
        check("post_hold_ready", {31'd0, req_ready},  32'd1);

        send(1'b1, F3_SB, 32'h103, 32'h12345677, lat, nwe);
        check("sb_nwe",   nwe, 1);
        check("sb_wa",    last_wa, 32'h100);
        check("sb_lat",   lat, 2);
        check("sb_rdata", resp_rdata, 32'h0);
        finish_resp();
        check("sb_mem", mem[widx(32'h100)], 32'h7799AABB);

        send(1'b0, F3_LH, 32'h100, 32'h0, lat, nwe);
        check("lh_rdata", resp_rdata, 32'hFFFFAABB);
        finish_resp();

        send(1'b0, F3_LH, 32'h101, 32'h0, lat, nwe);
        check("lh_o1_rdata", resp_rdata, 32'hFFFF99AA);
        check("lh_o1_fault", {31'd0, resp_fault}, 32'd0);
        finish_resp();

        poke(32'h104, 32'hAAAAAAAA);
        poke(32'h108, 32'hBBBBBBBB);
        send(1'b1, F3_SW, 32'h106, 32'h11223344, lat, nwe);
`ifdef LSU_MISALIGNED_EN
        check("swx_lat",   lat, 3);
        check("swx_nwe",   nwe, 2);
        check("swx_fault", {31'd0, resp_fault}, 32'd0);
        finish_resp();
        check("swx_w0", mem[widx(32'h104)], 32'h3344AAAA);
        check("swx_w1", mem[widx(32'h108)], 32'hBBBB1122);
`else
        check("swx_lat",   lat, 1);
        check("swx_nwe",   nwe, 0);
        check("swx_fault", {31'd0, resp_fault}, 32'd1);
        finish_resp();
        check("swx_w0", mem[widx(32'h104)], 32'hAAAAAAAA);
        check("swx_w1", mem[widx(32'h108)], 32'hBBBBBBBB);
`endif

        send(1'b0, 3'b011, 32'h100, 32'h0, lat, nwe);
        check("badld_fault", {31'd0, resp_fault}, 32'd1);
        check("badld_rdata", resp_rdata, 32'h0);
        check("badld_nwe",   nwe, 0);
        check("badld_lat",   lat, 1);
        finish_resp();

        send(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, lat, nwe);
        check("badst_fault", {31'd0, resp_fault}, 32'd1);
        check("badst_nwe",   nwe, 0);
        finish_resp();

        poke(32'hFFFFFFFC, 32'hDDCCBBAA);
        poke(32'h00000000, 32'h44332211);
        send(1'b0, F3_LW, 32'hFFFFFFFE, 32'h0, lat, nwe);
`ifdef LSU_MISALIGNED_EN
        check("wrap_rdata", resp_rdata, 32'h2211DDCC);
        check("wrap_ra0",   ra_log[0], 32'hFFFFFFFC);
        check("wrap_ra1",   ra_log[1], 32'h00000000);
        check("wrap_lat",   lat, 3);
`else
        check("wrap_fault", {31'd0, resp_fault}, 32'd1);
        check("wrap_lat",   lat, 1);
`endif
        finish_resp();

`ifdef LSU_MISALIGNED_EN
        poke(32'h104, 32'hAAAAAAAA);
        poke(32'h108, 32'hBBBBBBBB);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h106; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_acc0_we", {31'd0, mem_we}, 32'd1);
        check("rst_acc0_wa", mem_wa, 32'h104);
        @(posedge clk); #1;
        check("rst_acc1_we", {31'd0, mem_we}, 32'd1);
        check("rst_acc1_wa", mem_wa, 32'h108);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we",    {31'd0, mem_we},     32'd0);
        check("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_w0", mem[widx(32'h104)], 32'h3344AAAA);
        check("rst_mid_w1", mem[widx(32'h108)], 32'hBBBBBBBB);
`else
        poke(32'h104, 32'hAAAAAAAA);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h104; req_wdata = 32'h55555555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_acc0_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we",    {31'd0, mem_we},     32'd0);
        check("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_w0", mem[widx(32'h104)], 32'hAAAAAAAA);
`endif
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
